slave_spi: RTL and testbench
============================

# slave_spi

SPI slave (target) endpoint that answers the team's master SPI engine across the board or in loopback simulation. It oversamples the external SCLK/CS_N/MOSI in the `clk_i` domain and deserialises 8-bit frames to a one-cycle `rx_valid_o` strobe. It serialises a byte from a single-entry TX holding register onto MISO. CPOL/CPHA are parameters so the block pairs with any master mode setting.

## Interface
- `CPOL`, default 1'b0: SCLK idle level.
- `CPHA`, default 1'b0: 0 = sample on leading edge, shift on trailing; 1 = shift on leading, sample on trailing.
- `clk_i`  in  1  system clock; all logic is in this domain.
- `rst_i`  in  1  asynchronous, active-high reset.
- `spi_clk_i`  in  1  SCLK from master, asynchronous.
- `spi_cs_n_i`  in  1  chip select, active low, asynchronous.
- `spi_mosi_i`  in  1  serial data from master.
- `spi_miso_o`  out  1  serial data to master.
- `spi_miso_oe_o`  out  1  MISO output enable; high while CS is asserted (after synchronisation).
- `tx_data_i`  in  8  byte to send.
- `tx_valid_i`  in  1  `tx_data_i` valid.
- `tx_ready_o`  out  1  TX holding register empty.
- `rx_data_o`  out  8  last complete received byte.
- `rx_valid_o`  out  1  one-cycle strobe; `rx_data_o` updated.
- `busy_o`  out  1  frame in progress (synchronised CS low).

## Operation
- **Synchronisation:** SCLK, CS_N and MOSI each pass through a 2-flop synchroniser plus one history flop. Edges of SCLK and CS_N are detected from the history flop.
- **Edge classification:**
  - Leading edge = transition away from `CPOL`.
  - Sample edge = leading if `CPHA`=0, trailing if `CPHA`=1.
  - Shift edge = the other edge.
- **Bit order:** MSB first for both directions. The bit counter is 3 bits and wraps 7 -> 0.
- **FSM states:** IDLE, LOAD, SHIFT.
  - IDLE -> LOAD on synchronised CS fall.
  - LOAD (1 cycle): move the TX holding register to the shift register and mark holding empty. If holding is empty, load 8'h00 (underrun). Drive MISO with bit 7. Go to SHIFT.
  - SHIFT:
    - On each sample edge, shift MOSI into the RX shift register and increment the counter.
    - On each shift edge, advance the TX shift register. When `CPHA`=1, the first leading edge presents bit 7.
    - After the 8th sample edge: copy the RX shifter to `rx_data_o`, pulse `rx_valid_o`, and clear the counter.
    - If CS is still low, the next byte loads from holding exactly as in LOAD, at the first shift edge of the new byte for `CPHA`=1 or immediately for `CPHA`=0.
  - Any state -> IDLE on synchronised CS rise. A partial byte is discarded, no `rx_valid_o` is issued, the counter is cleared, and the TX shifter is discarded (the holding register is unaffected).
- **TX handshake:** the holding register captures `tx_data_i` when `tx_valid_i && tx_ready_o`. `tx_ready_o` = holding empty.
  - If a write and a load occur in the same cycle, the load takes the old contents and the new write is accepted in that cycle; holding remains full.
- **MISO drive:** `spi_miso_o` = 0 whenever `spi_miso_oe_o` = 0.
- **RX overrun:** none. `rx_data_o` is overwritten on every complete byte, with no backpressure.

## Timing
- **Reset values:** `spi_miso_o`=0, `spi_miso_oe_o`=0, `rx_data_o`=8'h00, `rx_valid_o`=0, `tx_ready_o`=1, `busy_o`=0. FSM resets to IDLE, counter to 0, holding register empty.
- **Edge latency:** a raw SPI edge is acted on 3 `clk_i` cycles later.
- **RX latency:** `rx_valid_o` is registered and asserted 4 `clk_i` cycles after the raw 8th sample edge.
- **SCLK limit:** each SCLK half-period must be at least 4 `clk_i` cycles. The CS-fall to first SCLK edge gap must also be at least 4 cycles. Behaviour outside these limits is undefined.
- **MISO latency:** MISO changes 4 `clk_i` cycles after the raw shift edge, which gives the master at least 0 cycles of setup margin at the 4-cycle minimum. A full half-period of margin is required above the minimum.
- **`rst_i` mid-frame:** all state returns immediately to reset values. The master sees MISO=0 for the remainder of the frame.

## Configuration
- `SLAVE_SPI_UNDERRUN_EN`
  - **Defined:** adds output `tx_underrun_o` (1 bit, reset 0). It is a sticky flag set when a load finds the holding register empty, and cleared by the input `underrun_clr_i` (1-cycle pulse). If set and clear occur in the same cycle, set wins.
  - **Undefined:** neither port exists; underrun silently sends 8'h00.

## Structure
- **`slave_spi_pkg`:**
  - State enum `slave_spi_state_t` (IDLE, LOAD, SHIFT).
  - `SPI_WIDTH` = 8.
  - `SPI_CNT_W` = 3.
  - `SPI_UNDERRUN_BYTE` = 8'h00.
- **Sub-module `slave_spi_sync`:** one instance per asynchronous input. It contains the 2-flop synchroniser and history flop, and outputs `level`, `rise`, `fall`.

## Test plan
- **Mode 0 RX:** CPOL=0/CPHA=0, SCLK half-period 8 cycles, master sends 8'hA5 -> a single `rx_valid_o` pulse with `rx_data_o`=8'hA5, 4 cycles after the 8th rising edge.
- **Mode 3 full duplex:** CPOL=1/CPHA=1, holding preloaded with 8'h3C, master sends 8'hC3 -> master captures 8'h3C and `rx_data_o`=8'hC3. `tx_ready_o` rises in the LOAD cycle.
- **Back-to-back frames:** CS held low for 3 bytes 8'h01, 8'h02, 8'h03, with TX writes 8'h10, 8'h20, 8'h30 issued on each `tx_ready_o` -> three `rx_valid_o` pulses in order, and the master receives 10/20/30.
- **Underrun:** CS falls with holding empty -> MISO bytes 8'h00. With the macro defined, `tx_underrun_o`=1 until `underrun_clr_i` is pulsed.
- **Abort:** CS rises after 5 bits -> no `rx_valid_o`, `busy_o`=0 three cycles later. The next full frame of 8'h5A is received correctly.
- **Async reset mid-frame:** assert `rst_i` at bit 4 -> all outputs at reset values within the same cycle. A subsequent frame of 8'hFF is received correctly.

Source files
------------

// File: rtl/slave_spi_pkg.sv
// slave_spi_pkg: shared types and constants for the SPI target endpoint
package slave_spi_pkg;

    localparam int SPI_WIDTH = 8;
    localparam int SPI_CNT_W = 3;
    localparam logic [SPI_WIDTH-1:0] SPI_UNDERRUN_BYTE = 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } slave_spi_state_t;

endpackage

// File: rtl/slave_spi_sync.sv
// slave_spi_sync: 2-flop synchroniser plus history flop with edge detection
module slave_spi_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync_q;
    logic hist;

    // resync the asynchronous input and keep one cycle of history for edges
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta   <= RST_VAL;
            sync_q <= RST_VAL;
            hist   <= RST_VAL;
        end else begin
            meta   <= din;
            sync_q <= meta;
            hist   <= sync_q;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~hist;
    assign fall  = ~sync_q & hist;

endmodule

// File: rtl/slave_spi.sv
// slave_spi: SPI target endpoint, MSB-first 8-bit frames, CPOL/CPHA parameterised.
// Define SLAVE_SPI_UNDERRUN_EN to add the sticky tx_underrun_o flag and its underrun_clr_i clear.
module slave_spi
    import slave_spi_pkg::*;
#(
    parameter logic CPOL = 1'b0,
    parameter logic CPHA = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 spi_clk_i,
    input  logic                 spi_cs_n_i,
    input  logic                 spi_mosi_i,
    output logic                 spi_miso_o,
    output logic                 spi_miso_oe_o,
    input  logic [SPI_WIDTH-1:0] tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    output logic [SPI_WIDTH-1:0] rx_data_o,
    output logic                 rx_valid_o,
    output logic                 busy_o
`ifdef SLAVE_SPI_UNDERRUN_EN
    ,
    input  logic                 underrun_clr_i,
    output logic                 tx_underrun_o
`endif
);

    logic sclk_level, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic mosi_level, mosi_rise, mosi_fall;
    logic unused_sync;

    slave_spi_state_t state, state_nxt;

    logic [SPI_CNT_W-1:0] cnt;
    logic [SPI_WIDTH-1:0] hold;
    logic [SPI_WIDTH-1:0] tx_shift;
    logic [SPI_WIDTH-1:0] rx_shift;
    logic [SPI_WIDTH-1:0] load_byte;
    logic                 hold_full;
    logic                 fresh;
    logic                 rx_done;
    logic                 miso_q;
    logic                 lead, trail, sample_e, shift_e;
    logic                 sample_now, shift_now, load_now;

    slave_spi_sync #(.RST_VAL(CPOL)) u_sclk (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .din   (spi_clk_i),
        .level (sclk_level),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    slave_spi_sync #(.RST_VAL(1'b1)) u_cs (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .din   (spi_cs_n_i),
        .level (cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    slave_spi_sync #(.RST_VAL(1'b0)) u_mosi (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .din   (spi_mosi_i),
        .level (mosi_level),
        .rise  (mosi_rise),
        .fall  (mosi_fall)
    );

    // only the SCLK edges and the MOSI level matter downstream
    assign unused_sync = ^{sclk_level, mosi_rise, mosi_fall};

    assign lead     = CPOL ? sclk_fall : sclk_rise;
    assign trail    = CPOL ? sclk_rise : sclk_fall;
    assign sample_e = CPHA ? trail : lead;
    assign shift_e  = CPHA ? lead : trail;

    // state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // next state: CS rise aborts from anywhere, LOAD always lasts one cycle
    always_comb begin
        state_nxt = cs_rise ? IDLE :
                    (state == IDLE) ? (cs_fall ? LOAD : IDLE) : SHIFT;
    end

    // control decode: a reload happens on the shift edge that opens a new byte,
    // except for the first CPHA=1 leading edge, which just presents the LOAD byte
    always_comb begin
        sample_now = (state == SHIFT) && sample_e && !cs_rise;
        shift_now  = (state == SHIFT) && shift_e && !cs_rise;
        load_now   = ((state == LOAD) && !cs_rise) || (shift_now && (cnt == '0) && !fresh);
        load_byte  = hold_full ? hold : SPI_UNDERRUN_BYTE;
        tx_ready_o = !hold_full || load_now;
        busy_o     = (state != IDLE);
    end

    // TX holding register; a write in a load cycle refills it after the load takes the old byte
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (tx_valid_i && tx_ready_o) begin
            hold      <= tx_data_i;
            hold_full <= 1'b1;
        end else if (load_now) begin
            hold_full <= 1'b0;
        end
    end

    // shift registers and bit counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_shift <= '0;
            rx_shift <= '0;
            cnt      <= '0;
            fresh    <= 1'b0;
            rx_done  <= 1'b0;
        end else begin
            rx_done <= sample_now && (&cnt);
            if (cs_rise) begin
                tx_shift <= '0;
                cnt      <= '0;
                fresh    <= 1'b0;
            end else begin
                if (load_now) begin
                    tx_shift <= load_byte;
                    fresh    <= CPHA && (state == LOAD);
                end else if (shift_now) begin
                    tx_shift <= fresh ? tx_shift : {tx_shift[SPI_WIDTH-2:0], 1'b0};
                    fresh    <= 1'b0;
                end
                if (sample_now) begin
                    rx_shift <= {rx_shift[SPI_WIDTH-2:0], mosi_level};
                    cnt      <= cnt + 1'b1;
                end
            end
        end
    end

    // registered outputs: completed byte strobe and the MISO bit
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_data_o  <= '0;
            rx_valid_o <= 1'b0;
            miso_q     <= 1'b0;
        end else begin
            rx_valid_o <= rx_done;
            miso_q     <= tx_shift[SPI_WIDTH-1];
            if (rx_done) rx_data_o <= rx_shift;
        end
    end

    assign spi_miso_oe_o = ~cs_level;
    assign spi_miso_o    = spi_miso_oe_o & miso_q;

`ifdef SLAVE_SPI_UNDERRUN_EN
    // sticky underrun flag; a set in the same cycle as a clear wins
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                       tx_underrun_o <= 1'b0;
        else if (load_now && !hold_full) tx_underrun_o <= 1'b1;
        else if (underrun_clr_i)         tx_underrun_o <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_slave_spi.sv
// tb_slave_spi: self-checking bench for slave_spi with a mode 0 and a mode 3 instance
module tb_slave_spi;

    localparam int H = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] sclk = 2'b10;
    logic [1:0] cs_n = 2'b11;
    logic [1:0] mosi = 2'b00;
    logic [1:0] tx_valid = 2'b00;
    logic [1:0] clr = 2'b00;
    logic [7:0] tx_data [2];
    wire  [1:0] miso, oe, tx_ready, rx_valid, busy, unr;
    wire  [7:0] rx_data [2];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int samp_cyc [2];
    int rx_cnt [2];
    int rx_lat [2];
    logic [7:0] rx_log [2][64];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    slave_spi #(.CPOL(1'b0), .CPHA(1'b0)) dut0 (
        .clk_i(clk), .rst_i(rst), .spi_clk_i(sclk[0]), .spi_cs_n_i(cs_n[0]), .spi_mosi_i(mosi[0]),
        .spi_miso_o(miso[0]), .spi_miso_oe_o(oe[0]), .tx_data_i(tx_data[0]), .tx_valid_i(tx_valid[0]),
        .tx_ready_o(tx_ready[0]), .rx_data_o(rx_data[0]), .rx_valid_o(rx_valid[0]), .busy_o(busy[0])
`ifdef SLAVE_SPI_UNDERRUN_EN
        , .underrun_clr_i(clr[0]), .tx_underrun_o(unr[0])
`endif
    );

    slave_spi #(.CPOL(1'b1), .CPHA(1'b1)) dut1 (
        .clk_i(clk), .rst_i(rst), .spi_clk_i(sclk[1]), .spi_cs_n_i(cs_n[1]), .spi_mosi_i(mosi[1]),
        .spi_miso_o(miso[1]), .spi_miso_oe_o(oe[1]), .tx_data_i(tx_data[1]), .tx_valid_i(tx_valid[1]),
        .tx_ready_o(tx_ready[1]), .rx_data_o(rx_data[1]), .rx_valid_o(rx_valid[1]), .busy_o(busy[1])
`ifdef SLAVE_SPI_UNDERRUN_EN
        , .underrun_clr_i(clr[1]), .tx_underrun_o(unr[1])
`endif
    );

`ifndef SLAVE_SPI_UNDERRUN_EN
    assign unr = 2'b00;
`endif

    // record every received byte and its latency from the raw sample edge
    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (rx_valid[m] === 1'b1) begin
                if (rx_cnt[m] < 64) rx_log[m][rx_cnt[m]] = rx_data[m];
                rx_lat[m] = cyc - samp_cyc[m];
                rx_cnt[m]++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // master side of one byte (or a partial byte); m=0 is mode 0, m=1 is mode 3
    task automatic xfer(input int m, input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            if (m == 0) begin
                mosi[m] = mo[i];
                tick(H);
                mi[i] = miso[m];
                sclk[m] = 1'b1;
                samp_cyc[m] = cyc;
                tick(H);
                sclk[m] = 1'b0;
            end else begin
                tick(H);
                sclk[m] = 1'b0;
                mosi[m] = mo[i];
                tick(H);
                mi[i] = miso[m];
                sclk[m] = 1'b1;
                samp_cyc[m] = cyc;
            end
        end
    endtask

    task automatic cs_high(input int m);
        tick(H);
        cs_n[m] = 1'b1;
        tick(H + 4);
    endtask

    task automatic write_tx(input int m, input logic [7:0] d);
        int t = 0;
        while (tx_ready[m] !== 1'b1 && t < 2000) begin
            tick();
            t++;
        end
        checks++;
        if (t >= 2000) begin
            failures++;
            $display("FAIL tx_ready_wait dut%0d got=0 exp=1", m);
        end
        tx_data[m] = d;
        tx_valid[m] = 1'b1;
        tick();
        tx_valid[m] = 1'b0;
    endtask

    task automatic test_reset;
        tick(3);
        for (int m = 0; m < 2; m++) begin
            checks++;
            if ({miso[m], oe[m], rx_data[m], rx_valid[m], tx_ready[m], busy[m]} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL reset_outputs dut%0d got=%b exp=%b", m,
                         {miso[m], oe[m], rx_data[m], rx_valid[m], tx_ready[m], busy[m]}, 13'b0000000000010);
            end
`ifdef SLAVE_SPI_UNDERRUN_EN
            checks++;
            if (unr[m] !== 1'b0) begin
                failures++;
                $display("FAIL reset_underrun dut%0d got=%b exp=0", m, unr[m]);
            end
`endif
        end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_mode0_rx;
        logic [7:0] mi;
        int r = rx_cnt[0];
        cs_n[0] = 1'b0;
        xfer(0, 8'hA5, 8, mi);
        cs_high(0);
        checks++;
        if (rx_cnt[0] !== r + 1) begin failures++; $display("FAIL mode0_rx_count got=%0d exp=%0d", rx_cnt[0], r + 1); end
        checks++;
        if (rx_log[0][r] !== 8'hA5) begin failures++; $display("FAIL mode0_rx_data got=%h exp=a5", rx_log[0][r]); end
        checks++;
        if (rx_lat[0] !== 4) begin failures++; $display("FAIL mode0_rx_latency got=%0d exp=4", rx_lat[0]); end
        checks++;
        if (mi !== 8'h00) begin failures++; $display("FAIL mode0_miso_empty got=%h exp=00", mi); end
    endtask

    task automatic test_mode3_duplex;
        logic [7:0] mi;
        int r = rx_cnt[1];
        write_tx(1, 8'h3C);
        checks++;
        if (tx_ready[1] !== 1'b0) begin failures++; $display("FAIL mode3_ready_full got=%b exp=0", tx_ready[1]); end
        cs_n[1] = 1'b0;
        tick(2);
        checks++;
        if (tx_ready[1] !== 1'b0) begin failures++; $display("FAIL mode3_ready_preload got=%b exp=0", tx_ready[1]); end
        tick();
        checks++;
        if (tx_ready[1] !== 1'b1) begin failures++; $display("FAIL mode3_ready_load got=%b exp=1", tx_ready[1]); end
        xfer(1, 8'hC3, 8, mi);
        cs_high(1);
        checks++;
        if (mi !== 8'h3C) begin failures++; $display("FAIL mode3_miso got=%h exp=3c", mi); end
        checks++;
        if (rx_cnt[1] !== r + 1 || rx_log[1][r] !== 8'hC3) begin
            failures++;
            $display("FAIL mode3_rx got=%h cnt=%0d exp=c3 cnt=%0d", rx_log[1][r], rx_cnt[1], r + 1);
        end
`ifdef SLAVE_SPI_UNDERRUN_EN
        checks++;
        if (unr[1] !== 1'b0) begin failures++; $display("FAIL mode3_no_underrun got=%b exp=0", unr[1]); end
`endif
    endtask

    task automatic test_back_to_back;
        logic [7:0] got [3];
        logic [7:0] exp_miso [3];
        int r = rx_cnt[0];
        exp_miso[0] = 8'h10;
        exp_miso[1] = 8'h20;
        exp_miso[2] = 8'h30;
        write_tx(0, 8'h10);
        fork
            begin
                cs_n[0] = 1'b0;
                for (int k = 0; k < 3; k++) xfer(0, 8'(k + 1), 8, got[k]);
                cs_high(0);
            end
            begin
                write_tx(0, 8'h20);
                write_tx(0, 8'h30);
            end
        join
        checks++;
        if (rx_cnt[0] !== r + 3) begin failures++; $display("FAIL b2b_rx_count got=%0d exp=%0d", rx_cnt[0], r + 3); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rx_log[0][r + k] !== 8'(k + 1)) begin
                failures++;
                $display("FAIL b2b_rx_byte%0d got=%h exp=%h", k, rx_log[0][r + k], 8'(k + 1));
            end
            checks++;
            if (got[k] !== exp_miso[k]) begin
                failures++;
                $display("FAIL b2b_miso_byte%0d got=%h exp=%h", k, got[k], exp_miso[k]);
            end
        end
    endtask

    task automatic test_underrun;
        logic [7:0] mi;
        logic [7:0] d = 8'($urandom);
        int r = rx_cnt[1];
`ifdef SLAVE_SPI_UNDERRUN_EN
        clr[1] = 1'b1;
        tick();
        clr[1] = 1'b0;
        checks++;
        if (unr[1] !== 1'b0) begin failures++; $display("FAIL underrun_pre_clear got=%b exp=0", unr[1]); end
`endif
        cs_n[1] = 1'b0;
        xfer(1, d, 8, mi);
        cs_high(1);
        checks++;
        if (mi !== 8'h00) begin failures++; $display("FAIL underrun_miso got=%h exp=00", mi); end
        checks++;
        if (rx_log[1][r] !== d) begin failures++; $display("FAIL underrun_rx got=%h exp=%h", rx_log[1][r], d); end
`ifdef SLAVE_SPI_UNDERRUN_EN
        tick(5);
        checks++;
        if (unr[1] !== 1'b1) begin failures++; $display("FAIL underrun_flag got=%b exp=1", unr[1]); end
        clr[1] = 1'b1;
        tick();
        clr[1] = 1'b0;
        checks++;
        if (unr[1] !== 1'b0) begin failures++; $display("FAIL underrun_clear got=%b exp=0", unr[1]); end
`endif
    endtask

    task automatic test_abort;
        logic [7:0] mi;
        int r = rx_cnt[0];
        cs_n[0] = 1'b0;
        xfer(0, 8'($urandom), 5, mi);
        tick(H);
        cs_n[0] = 1'b1;
        tick(2);
        checks++;
        if (busy[0] !== 1'b1) begin failures++; $display("FAIL abort_busy_2 got=%b exp=1", busy[0]); end
        tick();
        checks++;
        if (busy[0] !== 1'b0) begin failures++; $display("FAIL abort_busy_3 got=%b exp=0", busy[0]); end
        tick(20);
        checks++;
        if (rx_cnt[0] !== r) begin failures++; $display("FAIL abort_no_rx got=%0d exp=%0d", rx_cnt[0], r); end
        cs_n[0] = 1'b0;
        xfer(0, 8'h5A, 8, mi);
        cs_high(0);
        checks++;
        if (rx_cnt[0] !== r + 1 || rx_log[0][r] !== 8'h5A) begin
            failures++;
            $display("FAIL abort_next_frame got=%h cnt=%0d exp=5a cnt=%0d", rx_log[0][r], rx_cnt[0], r + 1);
        end
    endtask

    task automatic test_reset_midframe;
        logic [7:0] mi;
        int r;
        cs_n[0] = 1'b0;
        xfer(0, 8'($urandom), 4, mi);
        rst = 1'b1;
        #1;
        checks++;
        if ({miso[0], oe[0], rx_data[0], rx_valid[0], tx_ready[0], busy[0]} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL midreset_outputs got=%b exp=%b",
                     {miso[0], oe[0], rx_data[0], rx_valid[0], tx_ready[0], busy[0]}, 13'b0000000000010);
        end
        tick(2);
        rst = 1'b0;
        r = rx_cnt[0];
        xfer(0, 8'($urandom), 4, mi);
        checks++;
        if (mi !== 8'h00) begin failures++; $display("FAIL midreset_miso got=%h exp=00", mi); end
        cs_high(0);
        cs_n[0] = 1'b0;
        xfer(0, 8'hFF, 8, mi);
        cs_high(0);
        checks++;
        if (rx_cnt[0] !== r + 1 || rx_log[0][r] !== 8'hFF) begin
            failures++;
            $display("FAIL midreset_next_frame got=%h cnt=%0d exp=ff cnt=%0d", rx_log[0][r], rx_cnt[0], r + 1);
        end
    endtask

    // random single-byte frames: master gets the preloaded byte, or 00 if nothing was written
    task automatic test_random;
        for (int it = 0; it < 8; it++) begin
            int m = int'($urandom_range(0, 1));
            logic [7:0] d = 8'($urandom);
            logic [7:0] p = 8'($urandom);
            bit pre = 1'($urandom_range(0, 1));
            logic [7:0] exp_miso = pre ? p : 8'h00;
            logic [7:0] mi;
            int r = rx_cnt[m];
            if (pre) write_tx(m, p);
            cs_n[m] = 1'b0;
            xfer(m, d, 8, mi);
            cs_high(m);
            checks++;
            if (rx_cnt[m] !== r + 1 || rx_log[m][r] !== d) begin
                failures++;
                $display("FAIL random_rx dut%0d got=%h cnt=%0d exp=%h cnt=%0d", m, rx_log[m][r], rx_cnt[m], d, r + 1);
            end
            checks++;
            if (mi !== exp_miso) begin
                failures++;
                $display("FAIL random_miso dut%0d got=%h exp=%h", m, mi, exp_miso);
            end
        end
    endtask

    initial begin
        tx_data[0] = 8'h00;
        tx_data[1] = 8'h00;
        for (int m = 0; m < 2; m++) begin
            rx_cnt[m] = 0;
            rx_lat[m] = 0;
            samp_cyc[m] = 0;
        end
        test_reset;
        test_mode0_rx;
        test_mode3_duplex;
        test_back_to_back;
        test_underrun;
        test_abort;
        test_reset_midframe;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
